weight_mem_loader: RTL and testbench
====================================

Name: weight_mem_loader

Overview:
- Writer-side counterpart to the weight memory readout path: accepts a stream of W-bit weights over a valid/ready handshake and packs them COLS per row.
- Writes packed rows into an internal ROWS x COLS weight store.
- Raises load_done once the full matrix is written.
- Exposes a registered row-read port so the downstream row streamer and the bench can fetch whole rows.

Parameters:
- W, 4, bit width of one weight.
- COLS, 3, weights per row.
- ROWS, 3, rows in the store.
- AW, $clog2(ROWS) (minimum 1), row address width (derived localparam).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  pulse: begin (or restart) a load.
- in_valid  input  1  weight beat valid.
- in_data  input  W  weight value, row-major order (row 0 col 0 first).
- in_ready  output  1  loader can accept a beat.
- rd_addr  input  AW  row to read.
- rd_row  output  COLS*W  registered row data; column k at bits [k*W +: W].
- load_done  output  1  high while the full matrix is loaded.
- busy  output  1  high in LOAD state.
- row_count  output  AW+1  rows fully written in the current load.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - col_ptr=0, row_ptr=0, packing register=0.
  - All store entries cleared to 0.
  - in_ready=0, load_done=0, busy=0, row_count=0, rd_row=0.
- State machine: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD with col_ptr=0, row_ptr=0, row_count=0.
  - LOAD: in_ready=1, busy=1.
    - A beat is accepted when in_valid & in_ready; it is stored in packing slot col_ptr.
    - If col_ptr<COLS-1: col_ptr++.
    - If col_ptr==COLS-1: store[row_ptr] is written with the packing register, with in_data substituted into the last slot, in the same cycle. col_ptr->0, row_count++.
    - If row_ptr==ROWS-1 on that write: go to DONE. Otherwise row_ptr++.
  - DONE: in_ready=0, load_done=1, busy=0. start -> LOAD (new load); load_done drops the next cycle.
- start while in LOAD:
  - Aborts and restarts: pointers and row_count go to 0, and the partial row is discarded.
  - Rows already written keep their contents until overwritten.
  - A beat presented in the same cycle as start is not accepted: in_ready is combinationally 0 when start=1.
- Backpressure:
  - in_valid low in LOAD holds all state.
  - in_data is ignored when no beat is accepted.
- Write visibility: a row written at edge N is readable via rd_addr from cycle N onward, and appears on rd_row at edge N+1.
- Read port:
  - rd_row <= store[rd_addr] on every clock, 1-cycle latency, independent of state.
  - rd_addr>=ROWS returns all zeros.
  - Read and write to the same row in one cycle returns the old contents.
- Throughput: one beat per cycle. A full load takes ROWS*COLS accepted beats; load_done rises the cycle after the last beat.
- All pointers are compared with equality. There is no modulo arithmetic beyond the row and column wrap described above.

Decomposition:
- Shared package weight_mem_pkg:
  - default W/COLS/ROWS;
  - state enum {IDLE, LOAD, DONE};
  - row type logic [COLS*W-1:0].
- The reader-side row streamer also imports this package so row packing stays identical.
- One natural sub-module: weight_row_store, the ROWS x (COLS*W) array with an async-clear, synchronous write port and a registered read port.
- The FSM, pointers and packing logic stay in weight_mem_loader.

Test Plan:
- Reset mid-load: after 4 accepted beats, assert rst -> load_done=0, in_ready=0, row_count=0, and every rd_row read returns 0.
- Full load, continuous valid: start, then beats 1..9 -> row_count steps 1,2,3 after beats 3,6,9. load_done=1 the cycle after beat 9. rd_addr=0/1/2 give rd_row=12'h321, 12'h654, 12'h987.
- Backpressure and gaps: same data with in_valid toggling 1,0,0,1... -> identical final contents; no beat is lost or duplicated; in_ready stays 1 throughout LOAD.
- Beats outside LOAD: in_valid=1 with data F in IDLE and in DONE -> in_ready=0, store unchanged, row_count unchanged.
- Restart mid-row: load beats 1..4, pulse start with in_valid=1 and data=E, then load beats A,B,C -> beat E rejected; row 0 = 12'hCBA; row 1 = 0 (previous contents).
- Read boundary: rd_addr=3 with ROWS=3 -> rd_row=0. Write row 1 while rd_addr=1 -> old value that cycle, new value one cycle later.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Shared types and defaults for the weight memory loader and row streamer.
// Row packing: column k lives at bits [k*W +: W].
package weight_mem_pkg;

    localparam int W_DEF    = 4;
    localparam int COLS_DEF = 3;
    localparam int ROWS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    typedef logic [COLS_DEF*W_DEF-1:0] row_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_mem_loader_if.sv
// Weight beat stream: valid/ready handshake carrying one W-bit weight.
// master drives beats, slave (the loader) returns ready.
interface weight_mem_loader_if
    import weight_mem_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/weight_row_store.sv
// ROWS x (COLS*W) weight store: async clear, sync write, registered read.
// Out-of-range read addresses return zero; same-row read/write returns old data.
module weight_row_store
    import weight_mem_pkg::*;
#(
    parameter  int W    = W_DEF,
    parameter  int COLS = COLS_DEF,
    parameter  int ROWS = ROWS_DEF,
    localparam int AW   = addr_w(ROWS),
    localparam int RW   = COLS * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [RW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [RW-1:0] rdata_o
);

    logic [RW-1:0] mem_q [ROWS];
    logic [RW-1:0] rdata_q;
    logic          rvalid;

    assign rvalid  = ({1'b0, raddr_i} < (AW+1)'(ROWS));
    assign rdata_o = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= rvalid ? mem_q[raddr_i] : '0;
        end
    end

endmodule

// File: rtl/weight_mem_loader.sv
// Packs a stream of weights COLS per row into the row store.
// start (re)begins a load from row 0; load_done holds once all rows land.
module weight_mem_loader
    import weight_mem_pkg::*;
#(
    parameter  int W    = W_DEF,
    parameter  int COLS = COLS_DEF,
    parameter  int ROWS = ROWS_DEF,
    localparam int AW   = addr_w(ROWS),
    localparam int CW   = addr_w(COLS),
    localparam int RW   = COLS * W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    weight_mem_loader_if.slave  in_if,
    input  logic [AW-1:0]       rd_addr,
    output logic [RW-1:0]       rd_row,
    output logic                load_done,
    output logic                busy,
    output logic [AW:0]         row_count
);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [RW-1:0] pack_q, pack_d;
    logic [RW-1:0] wrow;
    logic          ready;
    logic          accept;
    logic          row_we;

    // A start in the same cycle as a beat always wins; the beat is refused.
    assign ready     = (state_q == LOAD) && !start;
    assign accept    = ready && in_if.in_valid;
    assign busy      = (state_q == LOAD);
    assign load_done = (state_q == DONE);
    assign row_count = cnt_q;

    assign in_if.in_ready = ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        row_we  = 1'b0;
        wrow    = pack_q;
        wrow[(COLS-1)*W +: W] = in_if.in_data;
        if (start) begin
            state_d = LOAD;
            col_d   = '0;
            row_d   = '0;
            cnt_d   = '0;
            pack_d  = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        pack_d[col_q*W +: W] = in_if.in_data;
                        if (col_q == CW'(COLS-1)) begin
                            row_we = 1'b1;
                            col_d  = '0;
                            cnt_d  = cnt_q + (AW+1)'(1);
                            if (row_q == AW'(ROWS-1)) begin
                                state_d = DONE;
                            end else begin
                                row_d = row_q + AW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                IDLE, DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
        end
    end

    weight_row_store #(
        .W    (W),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we_i    (row_we),
        .waddr_i (row_q),
        .wdata_i (wrow),
        .raddr_i (rd_addr),
        .rdata_o (rd_row)
    );

endmodule

// File: tb/tb_weight_mem_loader.sv
// Bench for weight_mem_loader: beat-counting reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_weight_mem_loader;
    import weight_mem_pkg::*;

    localparam int W    = W_DEF;
    localparam int COLS = COLS_DEF;
    localparam int ROWS = ROWS_DEF;
    localparam int AW   = addr_w(ROWS);
    localparam int RW   = COLS * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_row;
    logic          load_done;
    logic          busy;
    logic [AW:0]   row_count;

    int checks = 0;
    int errors = 0;

    weight_mem_loader_if #(.W(W)) bus ();

    weight_mem_loader #(
        .W    (W),
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_if     (bus),
        .rd_addr   (rd_addr),
        .rd_row    (rd_row),
        .load_done (load_done),
        .busy      (busy),
        .row_count (row_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: counts accepted beats of the current load.
    bit            m_load;
    bit            m_done;
    int            m_n;
    logic [W-1:0]  m_buf [COLS];
    logic [RW-1:0] m_store [ROWS];
    logic [RW-1:0] m_rd;

    task automatic model_reset();
        m_load = 0;
        m_done = 0;
        m_n    = 0;
        m_rd   = '0;
        for (int r = 0; r < ROWS; r++) m_store[r] = '0;
    endtask

    task automatic model_step();
        logic [RW-1:0] row;
        m_rd = (int'(rd_addr) < ROWS) ? m_store[rd_addr] : '0;
        if (start) begin
            m_load = 1;
            m_done = 0;
            m_n    = 0;
        end else if (m_load && bus.in_valid) begin
            m_buf[m_n % COLS] = bus.in_data;
            m_n++;
            if (m_n % COLS == 0) begin
                for (int k = 0; k < COLS; k++) row[k*W +: W] = m_buf[k];
                m_store[m_n / COLS - 1] = row;
            end
            if (m_n == ROWS * COLS) begin
                m_load = 0;
                m_done = 1;
            end
        end
    endtask

    // Inputs change just after the falling edge, so here they still hold
    // the values the preceding rising edge consumed.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            else model_step();
            chk("in_ready", 32'(bus.in_ready), 32'(m_load && !start));
            chk("busy", 32'(busy), 32'(m_load));
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("row_count", 32'(row_count), 32'(m_n / COLS));
            chk("rd_row", 32'(rd_row), 32'(m_rd));
        end
    end

    task automatic drive(input logic s, input logic v,
                         input logic [W-1:0] d, input logic [AW-1:0] a);
        start        = s;
        bus.in_valid = v;
        bus.in_data  = d;
        rd_addr      = a;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rd_addr      = '0;
        @(negedge clk);
        #1;
        do_reset();

        // Reset in the middle of a load.
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, W'(i), 0);
        rst = 1'b1;
        for (int a = 0; a < ROWS; a++) begin
            drive(0, 0, 0, AW'(a));
            chk("rst_rd_row", 32'(rd_row), 32'h0);
        end
        chk("rst_load_done", 32'(load_done), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_row_count", 32'(row_count), 32'h0);
        rst = 1'b0;
        for (int a = 0; a < ROWS; a++) begin
            drive(0, 0, 0, AW'(a));
            chk("post_rst_rd_row", 32'(rd_row), 32'h0);
        end

        // Full load with continuous valid.
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, W'(i), 0);
            if (i % 3 == 0) chk("full_row_count", 32'(row_count), 32'(i / 3));
        end
        chk("full_load_done", 32'(load_done), 32'h1);
        drive(0, 0, 0, 0);
        chk("full_row0", 32'(rd_row), 32'h321);
        drive(0, 0, 0, 1);
        chk("full_row1", 32'(rd_row), 32'h654);
        drive(0, 0, 0, 2);
        chk("full_row2", 32'(rd_row), 32'h987);

        // Beats offered in DONE are refused.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'hF, 0);
            chk("done_in_ready", 32'(bus.in_ready), 32'h0);
            chk("done_row_count", 32'(row_count), 32'h3);
        end
        drive(0, 0, 0, 0);
        chk("done_row0", 32'(rd_row), 32'h321);

        // Beats offered in IDLE are refused.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'hF, AW'(i));
            chk("idle_in_ready", 32'(bus.in_ready), 32'h0);
            chk("idle_row_count", 32'(row_count), 32'h0);
        end
        drive(0, 0, 0, 0);
        chk("idle_row0", 32'(rd_row), 32'h0);

        // Gappy valid pattern 1,0,0 with junk data on idle cycles.
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, W'(i), 0);
            if (i < 9) begin
                for (int g = 0; g < 2; g++) begin
                    d = W'($urandom);
                    drive(0, 0, d, 0);
                    chk("gap_in_ready", 32'(bus.in_ready), 32'h1);
                end
            end
        end
        chk("gap_load_done", 32'(load_done), 32'h1);
        drive(0, 0, 0, 0);
        chk("gap_row0", 32'(rd_row), 32'h321);
        drive(0, 0, 0, 1);
        chk("gap_row1", 32'(rd_row), 32'h654);
        drive(0, 0, 0, 2);
        chk("gap_row2", 32'(rd_row), 32'h987);

        // Restart mid-row: the beat alongside start is dropped.
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, W'(i), 0);
        drive(1, 1, 4'hE, 0);
        chk("restart_in_ready", 32'(bus.in_ready), 32'h0);
        drive(0, 1, 4'hA, 0);
        drive(0, 1, 4'hB, 0);
        drive(0, 1, 4'hC, 0);
        chk("restart_row_count", 32'(row_count), 32'h1);
        drive(0, 0, 0, 0);
        chk("restart_row0", 32'(rd_row), 32'hCBA);
        drive(0, 0, 0, 1);
        chk("restart_row1", 32'(rd_row), 32'h0);

        // Read boundary and read-during-write.
        drive(0, 0, 0, 3);
        chk("oob_rd_row", 32'(rd_row), 32'h0);
        drive(1, 0, 0, 0);
        drive(0, 1, 4'hA, 0);
        drive(0, 1, 4'hB, 0);
        drive(0, 1, 4'hC, 0);
        drive(0, 1, 4'hD, 1);
        drive(0, 1, 4'hE, 1);
        drive(0, 1, 4'hF, 1);
        chk("rdw_old", 32'(rd_row), 32'h0);
        drive(0, 0, 0, 1);
        chk("rdw_new", 32'(rd_row), 32'hFED);

        // Random traffic: starts, gaps, junk data, all read addresses.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0,
                  W'($urandom),
                  AW'($urandom_range(0, 3)));
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
